// File: rtl/mux8_pkg.sv
// ---------------------------------------------------------------------------
// mux8_pkg
// Shared definitions for the MUX8 round-robin arbiter slice.
//   N_REQ      number of requesters sharing the MUX8 result bus
//   IDX_W      width of a requester index
//   state_e    arbiter FSM states
//   idx_to_sel converts a requester index into MUX8's native {c1,c2,c3}
// ---------------------------------------------------------------------------
package mux8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // MUX8 selects data_in(idx+1) with c1/c2 as the upper index bits and c3 as
  // the inverted low bit, so index 0 maps to 3'b001.
  function automatic logic [2:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    return {idx[2], idx[1], ~idx[0]};
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin picker for 8 requesters. The search starts just
// after the previous owner and wraps around, so the last owner has the
// lowest priority.
//   req   in   8  request vector
//   last  in   3  index of the previous owner
//   pick  out  3  index of the chosen requester (don't care when any=0)
//   any   out  1  at least one request is present
// ---------------------------------------------------------------------------
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] last,
  output logic [2:0] pick,
  output logic       any
);

  logic [2:0]  start;
  logic [15:0] doubled;
  logic [7:0]  rot;
  logic [2:0]  offset;

  assign start   = last + 3'd1;
  assign doubled = {req, req};

  // Rotate the request vector so bit 0 is the requester right after the last
  // owner, priority-encode the lowest set bit, then add the rotation back.
  // The 3-bit add wraps naturally modulo 8.
  always_comb begin
    rot    = doubled[start +: 8];
    offset = '0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) begin
        offset = 3'(k);
      end
    end
    pick = start + offset;
    any  = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing the 32-bit MUX8 result bus between 8 sources.
// At most one owner holds the bus; an owner is limited to MAX_HOLD
// consecutive cycles, and every release is followed by one idle cycle.
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  synchronous active-high reset
//   req        in   8  req[i] asks for the bus on behalf of MUX8 data_in(i+1)
//   gnt        out  8  registered one-hot grant, zero when nobody owns the bus
//   gnt_valid  out  1  registered OR of gnt
//   gnt_idx    out  3  index of the current or most recent owner
//   c1,c2,c3   out  1  MUX8 select lines derived from gnt_idx
//   expire     out  1  one-cycle pulse when a grant is revoked at MAX_HOLD
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       expire
);

  import mux8_pkg::*;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             gntValid_q, gntValid_d;
  logic [2:0]       gntIdx_q, gntIdx_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             expire_q, expire_d;

  logic [2:0] pick;
  logic       anyReq;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (anyReq)
  );

  // Next-state logic. In IDLE the picker result is granted on the next edge.
  // In BUSY only the owner's request matters: dropping it releases the bus,
  // and holding it past MAX_HOLD cycles revokes the grant with an expire
  // pulse. gnt_idx is only rewritten on a new grant so the MUX8 selects keep
  // pointing at the last owner while the bus is idle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gntIdx_d  = gntIdx_q;
    last_d    = last_q;
    holdCnt_d = holdCnt_q;
    expire_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          gnt_d     = 8'b1 << pick;
          gntIdx_d  = pick;
          last_d    = pick;
          holdCnt_d = CNT_W'(1);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!req[gntIdx_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (holdCnt_q == MaxCnt) begin
          gnt_d    = '0;
          expire_d = 1'b1;
          state_d  = IDLE;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    gntValid_d = |gnt_d;
  end

  // State and output registers. The round-robin pointer resets to 7 so the
  // very first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gntValid_q <= 1'b0;
      gntIdx_q   <= '0;
      last_q     <= 3'd7;
      holdCnt_q  <= '0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gntValid_q <= gntValid_d;
      gntIdx_q   <= gntIdx_d;
      last_q     <= last_d;
      holdCnt_q  <= holdCnt_d;
      expire_q   <= expire_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_valid    = gntValid_q;
  assign gnt_idx      = gntIdx_q;
  assign {c1, c2, c3} = idx_to_sel(gntIdx_q);
  assign expire       = expire_q;

  // Structural invariants of the grant registers, checked every cycle
  // outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (gntValid_q == (|gnt_q));
      assert ((gnt_q == '0) || gnt_q[gntIdx_q]);
      assert (holdCnt_q <= MaxCnt);
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
// Drives two arbiters (MAX_HOLD=16 and MAX_HOLD=1) from the same request and
// reset stimulus and compares both against a behavioural model every cycle.
// Directed scenarios come first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt      [2];
  logic       gntValid [2];
  logic [2:0] gntIdx   [2];
  logic       c1       [2];
  logic       c2       [2];
  logic       c3       [2];
  logic       expire   [2];

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model state per DUT: owner index or -1 when the bus is free.
  int mOwner  [2];
  int mLast   [2];
  int mIdx    [2];
  int mHold   [2];
  bit mExpire [2];

  // MUX8 select pattern for each owner index, written out as a table.
  logic [2:0] selTab [8] = '{3'b001, 3'b000, 3'b011, 3'b010,
                             3'b101, 3'b100, 3'b111, 3'b110};

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt[0]),
    .gnt_valid (gntValid[0]),
    .gnt_idx   (gntIdx[0]),
    .c1        (c1[0]),
    .c2        (c2[0]),
    .c3        (c3[0]),
    .expire    (expire[0])
  );

  mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt[1]),
    .gnt_valid (gntValid[1]),
    .gnt_idx   (gntIdx[1]),
    .c1        (c1[1]),
    .c2        (c2[1]),
    .c3        (c3[1]),
    .expire    (expire[1])
  );

  function automatic int holdLimit(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d]  = -1;
      mLast[d]   = 7;
      mIdx[d]    = 0;
      mHold[d]   = 0;
      mExpire[d] = 1'b0;
    end
  endtask

  // One clock edge of the arbitration rules, applied to what was sampled.
  task automatic modelStep(input logic r, input logic [7:0] rq);
    if (r) begin
      modelReset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        mExpire[d] = 1'b0;
        if (mOwner[d] < 0) begin
          bit found = 1'b0;
          for (int i = 1; i <= 8; i++) begin
            int p = (mLast[d] + i) % 8;
            if (!found && rq[p]) begin
              found     = 1'b1;
              mOwner[d] = p;
              mIdx[d]   = p;
              mLast[d]  = p;
              mHold[d]  = 1;
            end
          end
        end else if (!rq[mOwner[d]]) begin
          mOwner[d] = -1;
        end else if (mHold[d] >= holdLimit(d)) begin
          mOwner[d]  = -1;
          mExpire[d] = 1'b1;
        end else begin
          mHold[d] = mHold[d] + 1;
        end
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] expGnt;
      expGnt = (mOwner[d] < 0) ? 8'h00 : (8'h01 << mOwner[d]);
      checkVal($sformatf("gnt_d%0d", d), gnt[d], expGnt);
      checkVal($sformatf("gnt_valid_d%0d", d), 8'(gntValid[d]), 8'(mOwner[d] >= 0));
      checkVal($sformatf("gnt_idx_d%0d", d), 8'(gntIdx[d]), 8'(mIdx[d]));
      checkVal($sformatf("sel_d%0d", d), 8'({c1[d], c2[d], c3[d]}), 8'(selTab[mIdx[d]]));
      checkVal($sformatf("expire_d%0d", d), 8'(expire[d]), 8'(mExpire[d]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] rq);
    rst = r;
    req = rq;
    @(posedge clk);
    modelStep(r, rq);
    #1;
    checkOutput();
  endtask

  initial begin
    int         order[$];
    int         lens[$];
    int         runLen;
    logic [7:0] prevG;
    logic [7:0] rq;

    modelReset();
    rst = 1'b1;
    req = 8'h00;

    // Reset and idle with no requests.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    repeat (5) applyStimulus(1'b0, 8'h00);
    checkVal("t1_gnt", gnt[0], 8'h00);
    checkVal("t1_sel", 8'({c1[0], c2[0], c3[0]}), 8'h01);

    // Two requesters; requester 0 wins first, requester 7 after the bubble.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h81);
    checkVal("t2_first_gnt", gnt[0], 8'h01);
    applyStimulus(1'b0, 8'h81);
    applyStimulus(1'b0, 8'h80);
    checkVal("t2_bubble", gnt[0], 8'h00);
    applyStimulus(1'b0, 8'h80);
    checkVal("t2_second_gnt", gnt[0], 8'h80);
    checkVal("t2_idx", 8'(gntIdx[0]), 8'd7);
    checkVal("t2_sel", 8'({c1[0], c2[0], c3[0]}), 8'h06);

    // Everyone requesting, each owner releasing after two cycles.
    applyStimulus(1'b1, 8'h00);
    prevG  = 8'h00;
    runLen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (order.size() < 9) begin
        rq = 8'hFF;
        if (mOwner[0] >= 0 && mHold[0] == 2) rq = 8'hFF & ~(8'h01 << mOwner[0]);
        applyStimulus(1'b0, rq);
        if (gnt[0] != 8'h00 && prevG == 8'h00) order.push_back(int'(gntIdx[0]));
        if (gnt[0] != 8'h00) runLen++;
        if (gnt[0] == 8'h00 && prevG != 8'h00) begin
          lens.push_back(runLen);
          runLen = 0;
        end
        prevG = gnt[0];
      end
    end
    checkVal("t3_grant_count", 8'(order.size()), 8'd9);
    for (int k = 0; k < 9; k++) begin
      if (k < order.size()) checkVal($sformatf("t3_order%0d", k), 8'(order[k]), 8'(k % 8));
    end
    checkVal("t3_len_count", 8'(lens.size() >= 8), 8'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < lens.size()) checkVal($sformatf("t3_len%0d", k), 8'(lens[k]), 8'd2);
    end

    // Single requester held: 16 cycles of grant, expire pulse, regrant.
    applyStimulus(1'b1, 8'h00);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 8'h04);
      checkVal($sformatf("t4_hold%0d", k), gnt[0], 8'h04);
      checkVal($sformatf("t4_noexp%0d", k), 8'(expire[0]), 8'd0);
    end
    applyStimulus(1'b0, 8'h04);
    checkVal("t4_revoked", gnt[0], 8'h00);
    checkVal("t4_expire", 8'(expire[0]), 8'd1);
    applyStimulus(1'b0, 8'h04);
    checkVal("t4_regrant", gnt[0], 8'h04);
    checkVal("t4_expire_done", 8'(expire[0]), 8'd0);

    // Owner 1 releases and re-requests at once; requester 2 goes first.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h06);
    checkVal("t5_owner1", gnt[0], 8'h02);
    applyStimulus(1'b0, 8'h04);
    applyStimulus(1'b0, 8'h06);
    checkVal("t5_idx", 8'(gntIdx[0]), 8'd2);
    checkVal("t5_sel", 8'({c1[0], c2[0], c3[0]}), 8'h03);

    // Reset in the middle of a grant, then a fresh grant.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h20);
    checkVal("t6_gnt", gnt[0], 8'h20);
    applyStimulus(1'b1, 8'h20);
    checkVal("t6_reset_gnt", gnt[0], 8'h00);
    checkVal("t6_reset_sel", 8'({c1[0], c2[0], c3[0]}), 8'h01);
    applyStimulus(1'b0, 8'h20);
    checkVal("t6_regrant", gnt[0], 8'h20);
    checkVal("t6_sel", 8'({c1[0], c2[0], c3[0]}), 8'h04);

    // Randomized requests with mostly-stable vectors and rare resets.
    rq = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 5) == 0) rq = 8'($urandom);
      applyStimulus(($urandom_range(0, 99) == 0), rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
